// File: rtl/rv32i_types.sv
// Shared types for the memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE, SERVE_I, SERVE_D)
//   CNT_W       : width of the performance counters
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  localparam int CNT_W = 32;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction-cache, data-cache and physical-memory signals
// that surround the arbiter.
//   slave  : the arbiter's view (requests and pmem_rdata/pmem_resp in,
//            pmem command and cache responses out)
//   master : the environment's view (caches plus memory), the mirror image
//
// Handshake: a cache holds its read/write request, address and wdata stable
// from assertion until the cycle in which its resp is 1; resp is a one-cycle
// pulse copied from pmem_resp, and the request may drop on the following
// cycle. The arbiter holds the pmem command until pmem_resp.
interface mem_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) ();
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/perf_counter.sv
// Free-running event counter, wraps modulo 2^32.
//   clk   : clock
//   rst_n : asynchronous active-low clear
//   inc   : add one on this rising edge
//   count : current value
module perf_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single physical-memory port.
//   clk, rst_n                : clock, asynchronous active-low reset
//   i_*                       : instruction-cache miss port (read only)
//   d_*                       : data-cache miss / writeback port
//   pmem_*                    : shared physical-memory port
//   cnt_i_grant/cnt_d_grant   : grants given to each side
//   cnt_conflict              : cycles in which the losing side was waiting
//   dbg_state                 : current FSM state
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,

  output logic [31:0]       cnt_i_grant,
  output logic [31:0]       cnt_d_grant,
  output logic [31:0]       cnt_conflict,
  output arb_state_t        dbg_state
);

  arb_state_t state, next_state;
  logic       last_d;     // 1 when D received the most recent grant
  logic       lat_read;   // command captured in the grant cycle
  logic       lat_write;
  logic       d_req;
  logic       grant_i, grant_d, conflict_inc;

  assign d_req     = d_read | d_write;
  assign dbg_state = state;

  // Next-state and grant decision.
  always_comb begin
    next_state   = state;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    conflict_inc = 1'b0;
    case (state)
      IDLE: begin
        if (i_read && d_req) begin
          conflict_inc = 1'b1;
          // The side not served last wins; last_d resets to 0 so D goes first.
          if (last_d) grant_i = 1'b1;
          else        grant_d = 1'b1;
        end else if (i_read) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        if (grant_i)      next_state = SERVE_I;
        else if (grant_d) next_state = SERVE_D;
      end
      SERVE_I: begin
        conflict_inc = d_req;
        if (pmem_resp) next_state = IDLE;
      end
      SERVE_D: begin
        conflict_inc = i_read;
        if (pmem_resp) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      lat_read  <= 1'b0;
      lat_write <= 1'b0;
    end else begin
      state <= next_state;
      if (grant_i) begin
        last_d    <= 1'b0;
        lat_read  <= 1'b1;
        lat_write <= 1'b0;
      end else if (grant_d) begin
        // Write wins if the data side illegally asserts both commands.
        last_d    <= 1'b1;
        lat_read  <= d_read & ~d_write;
        lat_write <= d_write;
      end
    end
  end

  // Output routing. In IDLE everything toward memory and both resps are 0;
  // a pmem_resp arriving in IDLE (e.g. from a transaction cut off by reset)
  // is therefore dropped.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    i_rdata      = pmem_rdata;
    d_rdata      = pmem_rdata;
    case (state)
      SERVE_I: begin
        // The I side only reads, so the latched command equals the live one
        // while the request is held and keeps the read alive if it drops.
        pmem_read    = lat_read;
        pmem_address = i_address;
        i_resp       = pmem_resp;
      end
      SERVE_D: begin
        if (d_req) begin
          pmem_write = d_write;
          pmem_read  = d_read & ~d_write;
        end else begin
          pmem_write = lat_write;
          pmem_read  = lat_read;
        end
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
      end
      default: ;
    endcase
  end

  perf_counter u_cnt_i (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (grant_i),
    .count (cnt_i_grant)
  );

  perf_counter u_cnt_d (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (grant_d),
    .count (cnt_d_grant)
  );

  perf_counter u_cnt_c (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (conflict_inc),
    .count (cnt_conflict)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single I read, first conflict, alternating
// conflicts, dropped D request, write precedence, reset mid-transaction,
// counter wrap.
module tb_mem_arbiter;
  import rv32i_types::*;

  localparam int LW = 256;
  localparam int AW = 32;

  logic clk;
  logic rst_n;
  logic [31:0] cnt_i_grant, cnt_d_grant, cnt_conflict;
  arb_state_t  dbg_state;

  mem_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();

  mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (bus.i_read),
    .i_address    (bus.i_address),
    .i_rdata      (bus.i_rdata),
    .i_resp       (bus.i_resp),
    .d_read       (bus.d_read),
    .d_write      (bus.d_write),
    .d_address    (bus.d_address),
    .d_wdata      (bus.d_wdata),
    .d_rdata      (bus.d_rdata),
    .d_resp       (bus.d_resp),
    .pmem_read    (bus.pmem_read),
    .pmem_write   (bus.pmem_write),
    .pmem_address (bus.pmem_address),
    .pmem_wdata   (bus.pmem_wdata),
    .pmem_rdata   (bus.pmem_rdata),
    .pmem_resp    (bus.pmem_resp),
    .cnt_i_grant  (cnt_i_grant),
    .cnt_d_grant  (cnt_d_grant),
    .cnt_conflict (cnt_conflict),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [LW-1:0] exp_q[$];
  logic [31:0]   exp_i, exp_d, exp_c;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_line(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input arb_state_t obs, input arb_state_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
    chk32({tag, "_cnt_i"}, cnt_i_grant, exp_i);
    chk32({tag, "_cnt_d"}, cnt_d_grant, exp_d);
    chk32({tag, "_cnt_c"}, cnt_conflict, exp_c);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory answers this cycle; the granted side must see resp and the data.
  task automatic respond(input bit side_d, input logic [LW-1:0] data);
    bus.pmem_rdata = data;
    bus.pmem_resp  = 1'b1;
    exp_q.push_back(data);
    #1;
    if (side_d) begin
      chk1("d_resp", bus.d_resp, 1'b1);
      chk1("i_resp_idle_side", bus.i_resp, 1'b0);
      chk_line("d_rdata", bus.d_rdata, exp_q.pop_front());
    end else begin
      chk1("i_resp", bus.i_resp, 1'b1);
      chk1("d_resp_idle_side", bus.d_resp, 1'b0);
      chk_line("i_rdata", bus.i_rdata, exp_q.pop_front());
    end
    tick();
    bus.pmem_resp = 1'b0;
  endtask

  logic [LW-1:0] pat_a5, pat_w;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_w  = {8{32'hDEAD_0001}};
    rst_n  = 1'b0;
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
    exp_i = 0; exp_d = 0; exp_c = 0;

    // Reset state
    tick(); tick();
    chk_state("rst_state", dbg_state, IDLE);
    chk1("rst_pmem_read", bus.pmem_read, 1'b0);
    chk1("rst_pmem_write", bus.pmem_write, 1'b0);
    chk_counters("rst");
    rst_n = 1'b1;
    tick();

    // Single I read
    bus.i_read = 1'b1; bus.i_address = 32'h0000_0060;
    #1;
    chk1("t1_idle_no_read", bus.pmem_read, 1'b0);
    tick(); exp_i++;
    chk_state("t1_state", dbg_state, SERVE_I);
    chk1("t1_pmem_read", bus.pmem_read, 1'b1);
    chk1("t1_pmem_write", bus.pmem_write, 1'b0);
    chk32("t1_addr", bus.pmem_address, 32'h0000_0060);
    chk_line("t1_wdata", bus.pmem_wdata, '0);
    tick(); tick();
    respond(1'b0, pat_a5);
    bus.i_read = 1'b0;
    chk_state("t1_idle", dbg_state, IDLE);
    chk_counters("t1");

    // First conflict after reset: D wins
    bus.i_read = 1'b1; bus.i_address = 32'h200;
    bus.d_write = 1'b1; bus.d_address = 32'h100; bus.d_wdata = pat_w;
    tick(); exp_d++; exp_c++;
    chk_state("t2_state_d", dbg_state, SERVE_D);
    chk1("t2_pmem_write", bus.pmem_write, 1'b1);
    chk1("t2_pmem_read", bus.pmem_read, 1'b0);
    chk32("t2_addr", bus.pmem_address, 32'h100);
    chk_line("t2_wdata", bus.pmem_wdata, pat_w);
    tick(); exp_c++;
    respond(1'b1, ~pat_a5); exp_c++;
    bus.d_write = 1'b0;
    chk_state("t2_gap_idle", dbg_state, IDLE);
    chk1("t2_gap_read", bus.pmem_read, 1'b0);
    tick(); exp_i++;
    chk_state("t2_state_i", dbg_state, SERVE_I);
    chk32("t2_addr_i", bus.pmem_address, 32'h200);
    chk_counters("t2");
    respond(1'b0, {8{32'h1234_5678}});
    bus.i_read = 1'b0;

    // Back-to-back conflicts alternate D, I, D, I
    bus.i_read = 1'b1; bus.i_address = 32'h300;
    bus.d_read = 1'b1; bus.d_address = 32'h400;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_c++;
      if (k % 2 == 0) begin
        exp_d++;
        chk_state("t3_grant_d", dbg_state, SERVE_D);
        chk32("t3_addr_d", bus.pmem_address, 32'h400);
      end else begin
        exp_i++;
        chk_state("t3_grant_i", dbg_state, SERVE_I);
        chk32("t3_addr_i", bus.pmem_address, 32'h300);
      end
      respond(k % 2 == 0, {8{32'($urandom_range(0, 32'hFFFF_FFFF))}});
      exp_c++;
    end
    bus.i_read = 1'b0; bus.d_read = 1'b0;
    chk_counters("t3");

    // D read dropped mid-transaction
    bus.d_read = 1'b1; bus.d_address = 32'h500;
    tick(); exp_d++;
    chk1("t4_pmem_read", bus.pmem_read, 1'b1);
    bus.d_read = 1'b0;
    #1;
    chk1("t4_hold_read", bus.pmem_read, 1'b1);
    tick();
    chk_state("t4_stay", dbg_state, SERVE_D);
    chk1("t4_hold_read2", bus.pmem_read, 1'b1);
    respond(1'b1, pat_w);
    chk_state("t4_idle", dbg_state, IDLE);
    chk1("t4_idle_read", bus.pmem_read, 1'b0);

    // Illegal read+write: write wins
    bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_address = 32'h540; bus.d_wdata = ~pat_w;
    tick(); exp_d++;
    chk1("t5_write", bus.pmem_write, 1'b1);
    chk1("t5_read", bus.pmem_read, 1'b0);
    chk_line("t5_wdata", bus.pmem_wdata, ~pat_w);
    respond(1'b1, '0);
    bus.d_read = 1'b0; bus.d_write = 1'b0;
    chk_counters("t5");

    // Reset in the middle of SERVE_I
    bus.i_read = 1'b1; bus.i_address = 32'h600;
    tick();
    chk1("t6_pre_read", bus.pmem_read, 1'b1);
    rst_n = 1'b0;
    #1;
    exp_i = 0; exp_d = 0; exp_c = 0;
    chk_state("t6_state", dbg_state, IDLE);
    chk1("t6_read", bus.pmem_read, 1'b0);
    chk32("t6_addr", bus.pmem_address, '0);
    chk1("t6_i_resp", bus.i_resp, 1'b0);
    chk_counters("t6");
    bus.i_read = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.pmem_rdata = pat_a5; bus.pmem_resp = 1'b1;
    #1;
    chk1("t6_stray_i_resp", bus.i_resp, 1'b0);
    chk1("t6_stray_d_resp", bus.d_resp, 1'b0);
    tick();
    bus.pmem_resp = 1'b0;
    chk_state("t6_still_idle", dbg_state, IDLE);
    // last_d cleared by reset: D wins again
    bus.i_read = 1'b1; bus.i_address = 32'h700;
    bus.d_read = 1'b1; bus.d_address = 32'h800;
    tick(); exp_d++; exp_c++;
    chk32("t6_conf_addr", bus.pmem_address, 32'h800);
    respond(1'b1, pat_a5); exp_c++;
    bus.d_read = 1'b0;
    tick(); exp_i++;
    chk_state("t6_then_i", dbg_state, SERVE_I);
    respond(1'b0, pat_w);
    bus.i_read = 1'b0;
    chk_counters("t6b");

    // Counter wrap
    force dut.u_cnt_d.count = 32'hFFFF_FFFF;
    #1;
    release dut.u_cnt_d.count;
    #1;
    chk32("t7_preload", cnt_d_grant, 32'hFFFF_FFFF);
    bus.d_read = 1'b1; bus.d_address = 32'h900;
    tick();
    chk32("t7_wrap", cnt_d_grant, 32'h0);
    respond(1'b1, pat_a5);
    bus.d_read = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
